// File: rtl/alu_rr_pkg.sv
// Shared definitions for the register-register ALU sequencer: state encoding,
// opcode constants, alu_op bit indices and IR field positions.
package alu_rr_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b00101;
    localparam logic [4:0] OP_AND  = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam int ALU_OP_W = 13;
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_MUL  = 2;
    localparam int ALU_DIV  = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_OR   = 5;
    localparam int ALU_SHR  = 6;
    localparam int ALU_SHRA = 7;
    localparam int ALU_SHL  = 8;
    localparam int ALU_ROR  = 9;
    localparam int ALU_ROL  = 10;
    localparam int ALU_NEG  = 11;
    localparam int ALU_NOT  = 12;

    localparam int OPC_LSB = 27;
    localparam int OPC_W   = 5;
    localparam int RA_LSB  = 23;
    localparam int RB_LSB  = 19;
    localparam int RC_LSB  = 15;

endpackage

// File: rtl/alu_rr_if.sv
// Datapath control strobes driven by the sequencer (master) into the datapath (slave).
interface alu_rr_if #(
    parameter int NUM_REGS = 16
);
    logic PCout, MARin, IncPC, PCin, MDMuxread, MDRin, MDRout, IRin, Yin;
    logic Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
    logic [NUM_REGS-1:0] Rin, Rout;
    logic [12:0]         alu_op;

    modport master (
        output PCout, MARin, IncPC, PCin, MDMuxread, MDRin, MDRout, IRin, Yin,
        output Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
        output Rin, Rout, alu_op
    );

    modport slave (
        input PCout, MARin, IncPC, PCin, MDMuxread, MDRin, MDRout, IRin, Yin,
        input Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
        input Rin, Rout, alu_op
    );
endinterface

// File: rtl/alu_rr_decode.sv
// Combinational IR decode: one-hot ALU operation, operation class, legality
// and one-hot register selects.
module alu_rr_decode
    import alu_rr_pkg::*;
#(
    parameter int NUM_REGS  = 16,
    parameter int REG_SEL_W = 4
) (
    input  logic [31:0]          ir,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic                 is_unary,
    output logic                 is_muldiv,
    output logic                 illegal,
    output logic [NUM_REGS-1:0]  ra_sel,
    output logic [NUM_REGS-1:0]  rb_sel,
    output logic [NUM_REGS-1:0]  rc_sel
);

    logic [OPC_W-1:0] opcode;
    logic             bad_op;
    logic             unused_low;

    assign opcode     = ir[OPC_LSB +: OPC_W];
    assign unused_low = ^ir[RC_LSB-1:0];

    // A field that names a non-existent register yields an all-zero select.
    function automatic logic [NUM_REGS-1:0] to_onehot(input logic [REG_SEL_W-1:0] f);
        logic [NUM_REGS-1:0] v;
        v = '0;
        if (int'(f) < NUM_REGS) v[f] = 1'b1;
        return v;
    endfunction

    assign ra_sel = to_onehot(ir[RA_LSB +: REG_SEL_W]);
    assign rb_sel = to_onehot(ir[RB_LSB +: REG_SEL_W]);
    assign rc_sel = to_onehot(ir[RC_LSB +: REG_SEL_W]);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        alu_op    = '0;
        is_unary  = 1'b0;
        is_muldiv = 1'b0;
        bad_op    = 1'b0;
        case (opcode)
            OP_ADD:  alu_op[ALU_ADD]  = 1'b1;
            OP_SUB:  alu_op[ALU_SUB]  = 1'b1;
            OP_OR:   alu_op[ALU_OR]   = 1'b1;
            OP_AND:  alu_op[ALU_AND]  = 1'b1;
            OP_SHR:  alu_op[ALU_SHR]  = 1'b1;
            OP_SHRA: alu_op[ALU_SHRA] = 1'b1;
            OP_SHL:  alu_op[ALU_SHL]  = 1'b1;
            OP_ROR:  alu_op[ALU_ROR]  = 1'b1;
            OP_ROL:  alu_op[ALU_ROL]  = 1'b1;
            OP_MUL:  begin alu_op[ALU_MUL] = 1'b1; is_muldiv = 1'b1; end
            OP_DIV:  begin alu_op[ALU_DIV] = 1'b1; is_muldiv = 1'b1; end
            OP_NEG:  begin alu_op[ALU_NEG] = 1'b1; is_unary  = 1'b1; end
            OP_NOT:  begin alu_op[ALU_NOT] = 1'b1; is_unary  = 1'b1; end
            default: bad_op = 1'b1;
        endcase
    end

    // Unary ops never read Rc, so its field is not checked for them.
    assign illegal = bad_op || (ra_sel == '0) || (rb_sel == '0) ||
                     (!is_unary && (rc_sel == '0));

endmodule

// File: rtl/alu_rr_sequencer.sv
// Fetch/execute control sequencer (T0-T6) for register-register ALU
// instructions, with memory-ready timeout and HI/LO write-back for MUL/DIV.
module alu_rr_sequencer
    import alu_rr_pkg::*;
#(
    parameter int NUM_REGS  = 16,
    parameter int REG_SEL_W = 4,
    parameter int MAX_WAIT  = 15
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic        fault,
    alu_rr_if.master    bus
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    state_t                state, state_next;
    logic [WAIT_W-1:0]     wait_cnt;
    logic                  wait_expired;
    logic [ALU_OP_W-1:0]   dec_alu_op;
    logic                  is_unary, is_muldiv, illegal;
    logic [NUM_REGS-1:0]   ra_sel, rb_sel, rc_sel;

    alu_rr_decode #(
        .NUM_REGS  (NUM_REGS),
        .REG_SEL_W (REG_SEL_W)
    ) u_decode (
        .ir        (ir),
        .alu_op    (dec_alu_op),
        .is_unary  (is_unary),
        .is_muldiv (is_muldiv),
        .illegal   (illegal),
        .ra_sel    (ra_sel),
        .rb_sel    (rb_sel),
        .rc_sel    (rc_sel)
    );

    assign wait_expired = (wait_cnt == WAIT_W'(MAX_WAIT));

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == S_T0)
                wait_cnt <= '0;
            else if (state == S_T1 && !mem_ready && !wait_expired)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (run) state_next = S_T0;
            S_T0:   state_next = S_T1;
            S_T1:   if (mem_ready)        state_next = S_T2;
                    else if (wait_expired) state_next = S_IDLE;
            S_T2:   state_next = S_T3;
            S_T3:   state_next = illegal ? S_IDLE : S_T4;
            S_T4:   state_next = S_T5;
            S_T5:   if (is_muldiv) state_next = S_T6;
                    else           state_next = run ? S_T0 : S_IDLE;
            S_T6:   state_next = run ? S_T0 : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.PCout     = 1'b0;
        bus.MARin     = 1'b0;
        bus.IncPC     = 1'b0;
        bus.PCin      = 1'b0;
        bus.MDMuxread = 1'b0;
        bus.MDRin     = 1'b0;
        bus.MDRout    = 1'b0;
        bus.IRin      = 1'b0;
        bus.Yin       = 1'b0;
        bus.Zlowin    = 1'b0;
        bus.Zhighin   = 1'b0;
        bus.Zlowout   = 1'b0;
        bus.Zhighout  = 1'b0;
        bus.HIin      = 1'b0;
        bus.LOin      = 1'b0;
        bus.Rin       = '0;
        bus.Rout      = '0;
        bus.alu_op    = '0;
        busy          = (state != S_IDLE);
        done          = 1'b0;
        fault         = 1'b0;
        case (state)
            S_T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.Zlowin = 1'b1;
            end
            S_T1: begin
                // mem_ready takes priority over an expiring wait count.
                if (mem_ready) begin
                    bus.Zlowout   = 1'b1;
                    bus.PCin      = 1'b1;
                    bus.MDMuxread = 1'b1;
                    bus.MDRin     = 1'b1;
                end else if (wait_expired) begin
                    fault = 1'b1;
                end
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                if (illegal) begin
                    fault = 1'b1;
                end else if (!is_unary) begin
                    bus.Rout = rb_sel;
                    bus.Yin  = 1'b1;
                end
            end
            S_T4: begin
                bus.Rout    = is_unary ? rb_sel : rc_sel;
                bus.alu_op  = dec_alu_op;
                bus.Zlowin  = 1'b1;
                bus.Zhighin = is_muldiv;
            end
            S_T5: begin
                bus.Zlowout = 1'b1;
                if (is_muldiv) begin
                    bus.LOin = 1'b1;
                end else begin
                    bus.Rin = ra_sel;
                    done    = 1'b1;
                end
            end
            S_T6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
                done         = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed per-cycle bench for alu_rr_sequencer with hand-computed strobe patterns.
module tb_alu_rr_sequencer;
    import alu_rr_pkg::*;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        run = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] ir = '0;
    logic        busy, done, fault;
    int          n_tests = 0;
    int          n_fail = 0;

    alu_rr_if #(.NUM_REGS(16)) bus ();

    alu_rr_sequencer #(
        .NUM_REGS  (16),
        .REG_SEL_W (4),
        .MAX_WAIT  (15)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .run       (run),
        .ir        (ir),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .bus       (bus)
    );

    always #5 clock = ~clock;

    localparam logic [17:0] M_FAULT  = 18'h00001;
    localparam logic [17:0] M_DONE   = 18'h00002;
    localparam logic [17:0] M_BUSY   = 18'h00004;
    localparam logic [17:0] M_LOIN   = 18'h00008;
    localparam logic [17:0] M_HIIN   = 18'h00010;
    localparam logic [17:0] M_ZHOUT  = 18'h00020;
    localparam logic [17:0] M_ZLOUT  = 18'h00040;
    localparam logic [17:0] M_ZHIN   = 18'h00080;
    localparam logic [17:0] M_ZLIN   = 18'h00100;
    localparam logic [17:0] M_YIN    = 18'h00200;
    localparam logic [17:0] M_IRIN   = 18'h00400;
    localparam logic [17:0] M_MDROUT = 18'h00800;
    localparam logic [17:0] M_MDRIN  = 18'h01000;
    localparam logic [17:0] M_MDMUX  = 18'h02000;
    localparam logic [17:0] M_PCIN   = 18'h04000;
    localparam logic [17:0] M_INCPC  = 18'h08000;
    localparam logic [17:0] M_MARIN  = 18'h10000;
    localparam logic [17:0] M_PCOUT  = 18'h20000;

    localparam logic [17:0] T0_S = M_PCOUT | M_MARIN | M_INCPC | M_ZLIN | M_BUSY;
    localparam logic [17:0] T1_S = M_ZLOUT | M_PCIN | M_MDMUX | M_MDRIN | M_BUSY;
    localparam logic [17:0] T2_S = M_MDROUT | M_IRIN | M_BUSY;

    function automatic logic [17:0] strobes();
        return {bus.PCout, bus.MARin, bus.IncPC, bus.PCin, bus.MDMuxread, bus.MDRin,
                bus.MDRout, bus.IRin, bus.Yin, bus.Zlowin, bus.Zhighin, bus.Zlowout,
                bus.Zhighout, bus.HIin, bus.LOin, busy, done, fault};
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [17:0] s, input logic [15:0] rin,
                                 input logic [15:0] rout, input logic [12:0] op);
        check({tag, " strobes"}, 32'(strobes()), 32'(s));
        check({tag, " Rin"},     32'(bus.Rin),   32'(rin));
        check({tag, " Rout"},    32'(bus.Rout),  32'(rout));
        check({tag, " alu_op"},  32'(bus.alu_op), 32'(op));
    endtask

    // One clock cycle: drive inputs at the falling edge, then sample outputs.
    task automatic cyc(input string tag, input logic r, input logic mr, input logic [17:0] s,
                       input logic [15:0] rin, input logic [15:0] rout, input logic [12:0] op);
        @(negedge clock);
        run       = r;
        mem_ready = mr;
        #1;
        check_outputs(tag, s, rin, rout, op);
    endtask

    task automatic fetch(input string tag, input logic hold_run);
        cyc({tag, " idle"}, 1'b1, 1'b1, '0, '0, '0, '0);
        cyc({tag, " t0"}, hold_run, 1'b1, T0_S, '0, '0, '0);
        cyc({tag, " t1"}, hold_run, 1'b1, T1_S, '0, '0, '0);
        cyc({tag, " t2"}, hold_run, 1'b1, T2_S, '0, '0, '0);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        #1;
        check_outputs("reset", '0, '0, '0, '0);
        @(negedge clock);
        clear = 1'b1;
        #1;
        check_outputs("post release", '0, '0, '0, '0);

        // OR R1,R2,R3
        ir = 32'h28918000;
        fetch("or", 1'b0);
        cyc("or t3", 1'b0, 1'b1, M_YIN | M_BUSY, '0, 16'h0004, '0);
        cyc("or t4", 1'b0, 1'b1, M_ZLIN | M_BUSY, '0, 16'h0008, 13'h0020);
        cyc("or t5", 1'b0, 1'b1, M_ZLOUT | M_DONE | M_BUSY, 16'h0002, '0, '0);
        cyc("or end", 1'b0, 1'b1, '0, '0, '0, '0);

        // MUL R0,R4,R5 with mem_ready low for three T1 cycles
        ir = mk_ir(OP_MUL, 4'd0, 4'd4, 4'd5);
        cyc("mul idle", 1'b1, 1'b0, '0, '0, '0, '0);
        cyc("mul t0", 1'b0, 1'b0, T0_S, '0, '0, '0);
        for (int i = 0; i < 3; i++) cyc("mul wait", 1'b0, 1'b0, M_BUSY, '0, '0, '0);
        cyc("mul t1", 1'b0, 1'b1, T1_S, '0, '0, '0);
        cyc("mul t2", 1'b0, 1'b1, T2_S, '0, '0, '0);
        cyc("mul t3", 1'b0, 1'b1, M_YIN | M_BUSY, '0, 16'h0010, '0);
        cyc("mul t4", 1'b0, 1'b1, M_ZLIN | M_ZHIN | M_BUSY, '0, 16'h0020, 13'h0004);
        cyc("mul t5", 1'b0, 1'b1, M_ZLOUT | M_LOIN | M_BUSY, '0, '0, '0);
        cyc("mul t6", 1'b0, 1'b1, M_ZHOUT | M_HIIN | M_DONE | M_BUSY, '0, '0, '0);
        cyc("mul end", 1'b0, 1'b1, '0, '0, '0, '0);

        // NOT R6,R7 with run held high: next T0 directly follows done
        ir = mk_ir(OP_NOT, 4'd6, 4'd7, 4'd0);
        fetch("not", 1'b1);
        cyc("not t3", 1'b1, 1'b1, M_BUSY, '0, '0, '0);
        cyc("not t4", 1'b1, 1'b1, M_ZLIN | M_BUSY, '0, 16'h0080, 13'h1000);
        cyc("not t5", 1'b1, 1'b1, M_ZLOUT | M_DONE | M_BUSY, 16'h0040, '0, '0);
        cyc("b2b t0", 1'b0, 1'b1, T0_S, '0, '0, '0);
        cyc("b2b t1", 1'b0, 1'b1, T1_S, '0, '0, '0);
        cyc("b2b t2", 1'b0, 1'b1, T2_S, '0, '0, '0);
        cyc("b2b t3", 1'b0, 1'b1, M_BUSY, '0, '0, '0);
        cyc("b2b t4", 1'b0, 1'b1, M_ZLIN | M_BUSY, '0, 16'h0080, 13'h1000);
        cyc("b2b t5", 1'b0, 1'b1, M_ZLOUT | M_DONE | M_BUSY, 16'h0040, '0, '0);
        cyc("b2b end", 1'b0, 1'b1, '0, '0, '0, '0);

        // mem_ready held low: 15 waiting cycles, fault in the next, no IRin
        ir = mk_ir(OP_ADD, 4'd1, 4'd2, 4'd3);
        cyc("to idle", 1'b1, 1'b0, '0, '0, '0, '0);
        cyc("to t0", 1'b0, 1'b0, T0_S, '0, '0, '0);
        for (int i = 0; i < 15; i++) cyc("to wait", 1'b0, 1'b0, M_BUSY, '0, '0, '0);
        cyc("to fault", 1'b0, 1'b0, M_FAULT | M_BUSY, '0, '0, '0);
        cyc("to end", 1'b0, 1'b0, '0, '0, '0, '0);

        // mem_ready arrives exactly at the timeout limit: no fault, ADD completes
        cyc("edge idle", 1'b1, 1'b0, '0, '0, '0, '0);
        cyc("edge t0", 1'b0, 1'b0, T0_S, '0, '0, '0);
        for (int i = 0; i < 15; i++) cyc("edge wait", 1'b0, 1'b0, M_BUSY, '0, '0, '0);
        cyc("edge t1", 1'b0, 1'b1, T1_S, '0, '0, '0);
        cyc("edge t2", 1'b0, 1'b1, T2_S, '0, '0, '0);
        cyc("edge t3", 1'b0, 1'b1, M_YIN | M_BUSY, '0, 16'h0004, '0);
        cyc("edge t4", 1'b0, 1'b1, M_ZLIN | M_BUSY, '0, 16'h0008, 13'h0001);
        cyc("edge t5", 1'b0, 1'b1, M_ZLOUT | M_DONE | M_BUSY, 16'h0002, '0, '0);
        cyc("edge end", 1'b0, 1'b1, '0, '0, '0, '0);

        // Opcode 11111: fault in T3, no register strobes
        ir = 32'hF8000000;
        fetch("ill", 1'b0);
        cyc("ill t3", 1'b0, 1'b1, M_FAULT | M_BUSY, '0, '0, '0);
        cyc("ill end", 1'b0, 1'b1, '0, '0, '0, '0);

        // DIV R3,R1,R2 aborted by clear during T4
        ir = mk_ir(OP_DIV, 4'd3, 4'd1, 4'd2);
        fetch("div", 1'b0);
        cyc("div t3", 1'b0, 1'b1, M_YIN | M_BUSY, '0, 16'h0002, '0);
        cyc("div t4", 1'b0, 1'b1, M_ZLIN | M_ZHIN | M_BUSY, '0, 16'h0004, 13'h0008);
        clear = 1'b0;
        #1;
        check_outputs("abort", '0, '0, '0, '0);
        @(negedge clock);
        clear = 1'b1;
        #1;
        check_outputs("abort release", '0, '0, '0, '0);
        cyc("abort idle1", 1'b0, 1'b1, '0, '0, '0, '0);
        cyc("abort idle2", 1'b0, 1'b1, '0, '0, '0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_rr_sequencer.md
# alu_rr_sequencer

Control sequencer for register-register ALU instructions in the datapath. Each instruction runs as a fetch/execute sequence T0–T6. The block drives the datapath enable strobes (PCout, MARin, IncPC, Zin/out, MDR, IR, Y, HI/LO, register in/out) that benches currently drive by hand. It generalises that flow in four ways: parametrised register count, full opcode decode, variable-latency memory through a ready handshake with timeout, and a HI/LO write-back phase for MUL/DIV. It sits between the IR and the Datapath control inputs.

## Interface
Parameters:
- NUM_REGS, 16, number of general registers; width of the one-hot select vectors
- REG_SEL_W, 4, width of each register field in the IR
- MAX_WAIT, 15, maximum number of T1 cycles spent waiting on mem_ready before a bus error

Ports:
- clock  in  1  single clock; all state changes on the rising edge
- clear  in  1  asynchronous, active-low reset
- run  in  1  level; while high, the block keeps executing instructions back-to-back
- ir  in  32  IR contents; opcode in [31:27], Ra in [26:23], Rb in [22:19], Rc in [18:15]
- mem_ready  in  1  memory read data on Mdatain is valid this cycle
- PCout, MARin, IncPC, PCin, MDMuxread, MDRin, MDRout, IRin, Yin  out  1 each  datapath strobes
- Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin  out  1 each  Z/HI/LO strobes
- Rin, Rout  out  NUM_REGS  one-hot register load/drive
- alu_op  out  13  one-hot, bit order ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse in the final execute state
- fault  out  1  one-cycle pulse on illegal opcode or bus timeout

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6. Outputs are Moore decodes of state, qualified by mem_ready only in T1. Every output not listed for a state is 0.
- IDLE: if run=1, go to T0.
- T0: PCout, MARin, IncPC, Zlowin.
- T1: wait for memory. While mem_ready=0, all outputs are 0 and wait_cnt increments. In the cycle mem_ready=1, assert Zlowout, PCin, MDMuxread, MDRin and go to T2. If wait_cnt reaches MAX_WAIT with mem_ready=0, pulse fault and go to IDLE.
- T2: MDRout, IRin. The IR is valid from T3 onward.
- T3: decode ir.
  - Illegal opcode: pulse fault, go to IDLE.
  - Binary op: Rout[Rb] and Yin.
  - Unary op (NEG, NOT): T3 has no outputs.
- T4:
  - Binary op: Rout[Rc], alu_op, Zlowin, plus Zhighin for MUL/DIV.
  - Unary op: Rout[Rb], alu_op, Zlowin.
- T5:
  - MUL/DIV: Zlowout, LOin.
  - All other ops: Zlowout, Rin[Ra], done.
- T6 (MUL/DIV only): Zhighout, HIin, done.
- After the done state: go to T0 if run=1, else IDLE.
- Opcodes: 00011 ADD, 00100 SUB, 00101 OR, 00110 AND, 00111 SHR, 01000 SHRA, 01001 SHL, 01010 ROR, 01011 ROL, 01111 MUL, 10000 DIV, 10001 NEG, 10010 NOT. All other opcodes are illegal.
- A register field ≥ NUM_REGS is illegal.
- Rin and Rout are always one-hot or all-zero; never more than one bit set.

## Timing
- Reset: clear=0 forces IDLE immediately (asynchronous) with wait_cnt=0. All outputs are 0 while clear=0 and in the first cycle after release.
- Latency with mem_ready=1 in T1:
  - ALU op: 6 cycles T0→T5, done in cycle 6.
  - MUL/DIV: 7 cycles, done in cycle 7.
  - Each low cycle of mem_ready adds one cycle.
- Back-to-back: T0 of the next instruction directly follows the done cycle; no IDLE cycle in between.
- Reset mid-instruction aborts the instruction; no done and no fault are emitted.
- Dropping run mid-instruction does not abort; the sequencer finishes and then goes to IDLE.
- wait_cnt clears on entry to T1.
- When mem_ready=1 in the same cycle wait_cnt reaches MAX_WAIT, mem_ready wins and there is no fault.

## Structure
- Package alu_rr_pkg holds:
  - state encoding
  - opcode constants
  - alu_op bit indices
  - instruction field positions
- Sub-module alu_rr_decode (combinational) takes ir and produces:
  - alu_op one-hot, is_unary, is_muldiv, illegal
  - one-hot Ra/Rb/Rc selects

## Test plan
- ir=0x28918000 (OR R1,R2,R3), mem_ready=1, run pulsed → exact per-cycle sequence:
  - T3: Rout=0x0004, Yin
  - T4: Rout=0x0008, alu_op=OR, Zlowin
  - T5: Rin=0x0002, Zlowout, done
  - Then IDLE.
- With the Datapath attached: R2=0x12, R3=0x14 → R1=0x16 after done.
- MUL R0,R4,R5 → T4 asserts both Zlowin and Zhighin; LOin in T5; HIin and done in T6.
- mem_ready low for 3 cycles in T1 → T1 lasts 4 cycles; MDRin high only in the last of them.
- mem_ready held low → fault after MAX_WAIT=15 cycles in T1, then IDLE, with no IRin ever asserted.
- Opcode 11111 → fault in T3, no Rin bit set.
- NOT R6,R7 → T3 has no outputs; T4: Rout=0x0080, alu_op=NOT.
- clear=0 during T4 → all outputs 0 immediately; after release, IDLE until run.
- run held high → second T0 in the cycle right after the first done.
